// File: rtl/decode_scoreboard.sv
// Register-hazard scoreboard gating issue into decode: per-register outstanding-write
// counters, hazard detection on rs1/rs2/rd, write-back retirement and sticky error.
module decode_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic [$clog2(NREG)-1:0]  issue_rd,
  input  logic [$clog2(NREG)-1:0]  issue_rs1,
  input  logic [$clog2(NREG)-1:0]  issue_rs2,
  input  logic                     issue_use_rs2,
  input  logic                     issue_wb,
  output logic                     issue_ready,
  input  logic                     wb_en,
  input  logic [$clog2(NREG)-1:0]  wb_rd,
  input  logic                     flush,
  output logic [NREG-1:0]          pending,
  output logic [5:0]               inflight,
  output logic [15:0]              stall_cycles,
  output logic                     wb_error
);

  localparam int unsigned IDX_W = $clog2(NREG);
  localparam int unsigned SUM_W = (IDX_W + CNT_W > 6) ? IDX_W + CNT_W : 7;

  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NREG-1:0]            pending_q, pending_d;
  logic [5:0]                 inflight_q, inflight_d;
  logic [15:0]                stall_q, stall_d;
  logic                       wb_error_q, wb_error_d;

  logic hazard;
  logic accept;
  logic retire;

  always_comb begin
    hazard = ((issue_rs1 != '0) && (cnt_q[issue_rs1] != '0))
          || (issue_use_rs2 && (issue_rs2 != '0) && (cnt_q[issue_rs2] != '0))
          || (issue_wb && (issue_rd != '0) && (cnt_q[issue_rd] != '0));
    issue_ready = !hazard && !flush;
    accept      = issue_valid && issue_ready && issue_wb && (issue_rd != '0);
    retire      = wb_en && (wb_rd != '0);
  end

  always_comb begin
    logic             inc;
    logic             dec;
    logic [SUM_W-1:0] sum;
    inc       = 1'b0;
    dec       = 1'b0;
    sum       = '0;
    cnt_d     = cnt_q;
    pending_d = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      inc = accept && (issue_rd == IDX_W'(i));
      dec = retire && (wb_rd == IDX_W'(i));
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc && !dec) begin
        if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec && !inc && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    cnt_d[0] = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      sum          = sum + SUM_W'(cnt_d[i]);
      pending_d[i] = (cnt_d[i] != '0);
    end
    inflight_d = (sum > SUM_W'(63)) ? 6'd63 : sum[5:0];
    // A same-register accept cancels the retire, so an empty counter is not an error then.
    wb_error_d = wb_error_q
               | (retire && !flush && (cnt_q[wb_rd] == '0)
                  && !(accept && (issue_rd == wb_rd)));
    stall_d    = stall_q + {15'd0, (issue_valid && !issue_ready)};
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      pending_q  <= '0;
      inflight_q <= '0;
      stall_q    <= '0;
      wb_error_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      stall_q    <= stall_d;
      wb_error_q <= wb_error_d;
    end
  end

  assign pending      = pending_q;
  assign inflight     = inflight_q;
  assign stall_cycles = stall_q;
  assign wb_error     = wb_error_q;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: directed scenarios plus random traffic
// compared against a per-register outstanding-write count model.
module tb_decode_scoreboard;

  logic        CLK = 1'b0;
  logic        reset;
  logic        issue_valid, issue_use_rs2, issue_wb, issue_ready;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2, wb_rd;
  logic        wb_en, flush;
  logic [31:0] pending;
  logic [5:0]  inflight;
  logic [15:0] stall_cycles;
  logic        wb_error;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned m_cnt [32];
  int unsigned m_stall;
  bit          m_err;
  logic        obs_ready, exp_ready;

  always #5 CLK = ~CLK;

  decode_scoreboard #(.NREG(32), .CNT_W(2)) dut (
    .CLK(CLK), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_use_rs2(issue_use_rs2), .issue_wb(issue_wb),
    .issue_ready(issue_ready), .wb_en(wb_en), .wb_rd(wb_rd), .flush(flush),
    .pending(pending), .inflight(inflight), .stall_cycles(stall_cycles),
    .wb_error(wb_error)
  );

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    for (int i = 0; i < 32; i++) p[i] = (m_cnt[i] != 0);
    return p;
  endfunction

  function automatic logic [5:0] m_inflight();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_cnt[i];
    return (s > 63) ? 6'd63 : 6'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_stall = 0;
    m_err   = 0;
  endtask

  // One clock: drive inputs, capture issue_ready before the edge, advance the model.
  task automatic step(input bit v, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input bit u2, input bit w,
                      input bit we, input logic [4:0] wr, input bit fl);
    bit haz, acc, ret;
    @(negedge CLK);
    issue_valid = v; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_use_rs2 = u2; issue_wb = w; wb_en = we; wb_rd = wr; flush = fl;
    #1;
    obs_ready = issue_ready;
    haz = (rs1 != 0 && m_cnt[rs1] != 0) || (u2 && rs2 != 0 && m_cnt[rs2] != 0)
       || (w && rd != 0 && m_cnt[rd] != 0);
    exp_ready = !haz && !fl;
    acc = v && exp_ready && w && rd != 0;
    ret = we && wr != 0;
    @(posedge CLK);
    if (v && !exp_ready) m_stall = (m_stall + 1) % 65536;
    if (fl) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    end else if (!(acc && ret && rd == wr)) begin
      if (acc && m_cnt[rd] < 3) m_cnt[rd]++;
      if (ret) begin
        if (m_cnt[wr] > 0) m_cnt[wr]--;
        else m_err = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_use_rs2 = 0; issue_wb = 0; wb_en = 0; wb_rd = 0; flush = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    repeat (3) idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", obs_ready);
    end
    n_checks++;
    if (pending !== 32'h0 || inflight !== 6'd0) begin
      n_fail++; $display("FAIL reset_state: pending %h inflight %0d want 0/0", pending, inflight);
    end
    n_checks++;
    if (stall_cycles !== 16'd0 || wb_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_counters: stall %0d err %b want 0/0", stall_cycles, wb_error);
    end
  endtask

  task automatic test_x0();
    step(1, 0, 0, 0, 1, 1, 0, 0, 0);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL x0_ready: got %b want 1", obs_ready);
    end
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    n_checks++;
    if (pending !== 32'h0 || inflight !== 6'd0 || wb_error !== 1'b0) begin
      n_fail++; $display("FAIL x0_state: pending %h inflight %0d err %b want 0/0/0",
                         pending, inflight, wb_error);
    end
  endtask

  task automatic test_raw_stall();
    logic [15:0] s0;
    s0 = stall_cycles;
    step(1, 5, 0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (pending !== 32'h20 || inflight !== 6'd1) begin
      n_fail++; $display("FAIL raw_alloc: pending %h inflight %0d want 00000020/1", pending, inflight);
    end
    for (int c = 1; c <= 3; c++) begin
      step(1, 6, 5, 0, 0, 0, (c == 3), 5, 0);
      n_checks++;
      if (obs_ready !== 1'b0) begin
        n_fail++; $display("FAIL raw_stall_c%0d: ready %b want 0", c, obs_ready);
      end
    end
    step(1, 6, 5, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_release: ready %b want 1", obs_ready);
    end
    n_checks++;
    if (16'(stall_cycles - s0) !== 16'd3) begin
      n_fail++; $display("FAIL raw_stall_count: delta %0d want 3", 16'(stall_cycles - s0));
    end
  endtask

  task automatic test_same_cycle();
    step(1, 7, 0, 0, 0, 1, 0, 0, 0);
    step(1, 9, 0, 0, 0, 1, 1, 7, 0);
    n_checks++;
    if (pending !== 32'h200 || inflight !== 6'd1) begin
      n_fail++; $display("FAIL same_cycle_swap: pending %h inflight %0d want 00000200/1", pending, inflight);
    end
    step(1, 7, 0, 0, 0, 1, 1, 7, 0);
    n_checks++;
    if (obs_ready !== 1'b1) begin
      n_fail++; $display("FAIL same_reg_ready: got %b want 1", obs_ready);
    end
    n_checks++;
    if (pending !== 32'h200 || wb_error !== 1'b0) begin
      n_fail++; $display("FAIL same_reg_net0: pending %h err %b want 00000200/0", pending, wb_error);
    end
    step(0, 0, 0, 0, 0, 0, 1, 9, 0);
  endtask

  task automatic test_spurious_wb();
    step(0, 0, 0, 0, 0, 0, 1, 12, 0);
    n_checks++;
    if (wb_error !== 1'b1 || pending[12] !== 1'b0) begin
      n_fail++; $display("FAIL spurious_wb: err %b pend12 %b want 1/0", wb_error, pending[12]);
    end
    repeat (2) idle();
    n_checks++;
    if (wb_error !== 1'b1) begin
      n_fail++; $display("FAIL spurious_sticky: err %b want 1", wb_error);
    end
  endtask

  task automatic test_flush();
    logic [15:0] s0;
    step(1, 3, 0, 0, 0, 1, 0, 0, 0);
    step(1, 4, 0, 0, 0, 1, 0, 0, 0);
    step(1, 6, 0, 0, 0, 1, 0, 0, 0);
    n_checks++;
    if (pending !== 32'h58 || inflight !== 6'd3) begin
      n_fail++; $display("FAIL flush_setup: pending %h inflight %0d want 00000058/3", pending, inflight);
    end
    s0 = stall_cycles;
    step(1, 8, 0, 0, 0, 1, 0, 0, 1);
    n_checks++;
    if (obs_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready: got %b want 0", obs_ready);
    end
    n_checks++;
    if (pending !== 32'h0 || inflight !== 6'd0) begin
      n_fail++; $display("FAIL flush_clear: pending %h inflight %0d want 0/0", pending, inflight);
    end
    n_checks++;
    if (16'(stall_cycles - s0) !== 16'd1 || wb_error !== 1'b1) begin
      n_fail++; $display("FAIL flush_keep: stall delta %0d err %b want 1/1",
                         16'(stall_cycles - s0), wb_error);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), ($urandom_range(0, 40) == 0));
      n_checks++;
      if (obs_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b want %b", n, obs_ready, exp_ready);
      end
      n_checks++;
      if (pending !== m_pending() || inflight !== m_inflight()) begin
        n_fail++; $display("FAIL rand_state[%0d]: pending %h inflight %0d want %h/%0d",
                           n, pending, inflight, m_pending(), m_inflight());
      end
      n_checks++;
      if (stall_cycles !== 16'(m_stall) || wb_error !== m_err) begin
        n_fail++; $display("FAIL rand_counters[%0d]: stall %0d err %b want %0d/%b",
                           n, stall_cycles, wb_error, m_stall, m_err);
      end
    end
  endtask

  task automatic test_midop_reset();
    step(1, 10, 0, 0, 0, 1, 0, 0, 0);
    step(1, 11, 10, 0, 0, 1, 0, 0, 0);
    @(posedge CLK);
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (pending !== 32'h0 || inflight !== 6'd0 || stall_cycles !== 16'd0 || wb_error !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset: pending %h inflight %0d stall %0d err %b want all 0",
                         pending, inflight, stall_cycles, wb_error);
    end
    @(negedge CLK);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_x0();
    test_raw_stall();
    test_same_cycle();
    test_spurious_wb();
    test_flush();
    test_random();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
